// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared widths, write-enable polarity and responder state encodings
package data_memory_responder_pkg;

    localparam int RAM_ADDRESS_BITWIDTH = 10;
    localparam logic RAM_WRITE_ENABLE = 1'b1;
    localparam int DMR_COUNT_BITWIDTH = 4;

    typedef enum logic [1:0] {
        DMR_STATE_IDLE = 2'd0,
        DMR_STATE_WAIT = 2'd1,
        DMR_STATE_RESP = 2'd2
    } dmr_state_t;

    function automatic logic [31:0] byte_lane_mask(input logic [3:0] byte_en);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{byte_en[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - MEM-stage request/response bundle; req_byte_en exists only with DATA_MEMORY_RESPONDER_BYTE_STRB_EN
interface data_memory_responder_if #(
    parameter int RAM_ADDRESS_BITWIDTH = 10
);
    logic                            req_valid;
    logic                            req_wren;
    logic [RAM_ADDRESS_BITWIDTH-1:0] req_address;
    logic [31:0]                     req_write_data;
`ifdef DATA_MEMORY_RESPONDER_BYTE_STRB_EN
    logic [3:0]                      req_byte_en;
`endif
    logic                            req_ready;
    logic                            resp_valid;
    logic [31:0]                     resp_data;
    logic                            busy;

`ifdef DATA_MEMORY_RESPONDER_BYTE_STRB_EN
    modport master (
        output req_valid, req_wren, req_address, req_write_data, req_byte_en,
        input  req_ready, resp_valid, resp_data, busy
    );
    modport slave (
        input  req_valid, req_wren, req_address, req_write_data, req_byte_en,
        output req_ready, resp_valid, resp_data, busy
    );
`else
    modport master (
        output req_valid, req_wren, req_address, req_write_data,
        input  req_ready, resp_valid, resp_data, busy
    );
    modport slave (
        input  req_valid, req_wren, req_address, req_write_data,
        output req_ready, resp_valid, resp_data, busy
    );
`endif

endinterface

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - single-port word array with byte enables and registered read data
module data_memory_array #(
    parameter int INDEX_BITWIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      wren,
    input  logic [3:0]                byte_en,
    input  logic [INDEX_BITWIDTH-1:0] index,
    input  logic [31:0]               write_data,
    output logic [31:0]               read_data
);
    import data_memory_responder_pkg::*;

    logic [31:0] mem [2**INDEX_BITWIDTH];
    logic [31:0] lane_mask;
    logic        do_write;

    assign lane_mask = byte_lane_mask(byte_en);
    assign do_write  = en && (wren == RAM_WRITE_ENABLE);

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[index] <= (mem[index] & ~lane_mask) | (write_data & lane_mask);
        end
    end

    // Read register doubles as the response data: a store response reports zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data <= '0;
        end else if (en) begin
            read_data <= do_write ? 32'd0 : mem[index];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - fixed-latency load/store responder; byte strobes with DATA_MEMORY_RESPONDER_BYTE_STRB_EN
module data_memory_responder #(
    parameter int RAM_ADDRESS_BITWIDTH = data_memory_responder_pkg::RAM_ADDRESS_BITWIDTH,
    parameter int READ_LATENCY         = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    data_memory_responder_if.slave bus
);
    import data_memory_responder_pkg::*;

    localparam int IW = RAM_ADDRESS_BITWIDTH - 2;
    localparam logic [DMR_COUNT_BITWIDTH-1:0] LOAD_COUNT = DMR_COUNT_BITWIDTH'(READ_LATENCY - 1);
    localparam logic DIRECT_RESP = (READ_LATENCY == 1);

    dmr_state_t                    state;
    logic [DMR_COUNT_BITWIDTH-1:0] count;
    logic                          cap_wren;
    logic [IW-1:0]                 cap_index;
    logic [31:0]                   cap_write_data;
    logic [3:0]                    cap_byte_en;

    logic          in_idle;
    logic          accept;
    logic          commit;
    logic [3:0]    live_byte_en;
    logic          arr_wren;
    logic [IW-1:0] arr_index;
    logic [31:0]   arr_write_data;
    logic [3:0]    arr_byte_en;
    logic          unused_addr_bits;

`ifdef DATA_MEMORY_RESPONDER_BYTE_STRB_EN
    assign live_byte_en = bus.req_byte_en;
`else
    assign live_byte_en = 4'hF;
`endif

    assign unused_addr_bits = ^bus.req_address[1:0];

    assign in_idle       = (state == DMR_STATE_IDLE);
    assign bus.req_ready = in_idle & ~reset;
    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.busy      = ~in_idle;
    assign bus.resp_valid = (state == DMR_STATE_RESP);

    // Commit happens on the edge entering RESP; with latency 1 that is the accept edge itself,
    // so the array must see the live request rather than the captured copy.
    assign commit = ((state == DMR_STATE_WAIT) && (count == DMR_COUNT_BITWIDTH'(1)))
                  || (accept && DIRECT_RESP);

    assign arr_wren       = in_idle ? bus.req_wren                  : cap_wren;
    assign arr_index      = in_idle ? bus.req_address[RAM_ADDRESS_BITWIDTH-1:2] : cap_index;
    assign arr_write_data = in_idle ? bus.req_write_data            : cap_write_data;
    assign arr_byte_en    = in_idle ? live_byte_en                  : cap_byte_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= DMR_STATE_IDLE;
            count          <= '0;
            cap_wren       <= 1'b0;
            cap_index      <= '0;
            cap_write_data <= '0;
            cap_byte_en    <= '0;
        end else begin
            case (state)
                DMR_STATE_IDLE: begin
                    if (accept) begin
                        cap_wren       <= bus.req_wren;
                        cap_index      <= bus.req_address[RAM_ADDRESS_BITWIDTH-1:2];
                        cap_write_data <= bus.req_write_data;
                        cap_byte_en    <= live_byte_en;
                        count          <= LOAD_COUNT;
                        state          <= DIRECT_RESP ? DMR_STATE_RESP : DMR_STATE_WAIT;
                    end
                end
                DMR_STATE_WAIT: begin
                    count <= count - DMR_COUNT_BITWIDTH'(1);
                    if (count == DMR_COUNT_BITWIDTH'(1)) begin
                        state <= DMR_STATE_RESP;
                    end
                end
                DMR_STATE_RESP: begin
                    state <= DMR_STATE_IDLE;
                end
                default: begin
                    state <= DMR_STATE_IDLE;
                end
            endcase
        end
    end

    data_memory_array #(
        .INDEX_BITWIDTH(IW)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .en         (commit),
        .wren       (arr_wren),
        .byte_en    (arr_byte_en),
        .index      (arr_index),
        .write_data (arr_write_data),
        .read_data  (bus.resp_data)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed bench for latency-2 and latency-1 responders; byte strobes with DATA_MEMORY_RESPONDER_BYTE_STRB_EN
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wren = 1'b0;
    logic [9:0]  req_address = '0;
    logic [31:0] req_write_data = '0;
    logic [3:0]  byte_en = 4'hF;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_memory_responder_if #(.RAM_ADDRESS_BITWIDTH(10)) bus2 ();
    data_memory_responder_if #(.RAM_ADDRESS_BITWIDTH(10)) bus1 ();

    assign bus2.req_valid      = req_valid & ~sel;
    assign bus1.req_valid      = req_valid & sel;
    assign bus2.req_wren       = req_wren;
    assign bus1.req_wren       = req_wren;
    assign bus2.req_address    = req_address;
    assign bus1.req_address    = req_address;
    assign bus2.req_write_data = req_write_data;
    assign bus1.req_write_data = req_write_data;
`ifdef DATA_MEMORY_RESPONDER_BYTE_STRB_EN
    assign bus2.req_byte_en    = byte_en;
    assign bus1.req_byte_en    = byte_en;
`endif

    logic        obs_ready, obs_resp_valid, obs_busy;
    logic [31:0] obs_resp_data;
    assign obs_ready      = sel ? bus1.req_ready  : bus2.req_ready;
    assign obs_resp_valid = sel ? bus1.resp_valid : bus2.resp_valid;
    assign obs_busy       = sel ? bus1.busy       : bus2.busy;
    assign obs_resp_data  = sel ? bus1.resp_data  : bus2.resp_data;

    data_memory_responder #(.RAM_ADDRESS_BITWIDTH(10), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));
    data_memory_responder #(.RAM_ADDRESS_BITWIDTH(10), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    // One access from an idle negedge; returns at the negedge of the first idle cycle after the response.
    task automatic access(input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input bit perturb, input string nm);
        int lat;
        logic [31:0] want;
        lat = sel ? 1 : 2;
        vectors++;
        if (obs_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept req_ready got %b want 1", nm, obs_ready);
        end
        req_valid = 1'b1; req_wren = w; req_address = a; req_write_data = d;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            vectors++;
            if (obs_resp_valid !== logic'(k == lat)) begin
                miscompares++;
                $display("FAIL %s cyc%0d resp_valid got %b want %b", nm, k, obs_resp_valid, k == lat);
            end
            vectors++;
            if (obs_busy !== logic'(k <= lat)) begin
                miscompares++;
                $display("FAIL %s cyc%0d busy got %b want %b", nm, k, obs_busy, k <= lat);
            end
            vectors++;
            if (obs_ready !== logic'(k > lat)) begin
                miscompares++;
                $display("FAIL %s cyc%0d req_ready got %b want %b", nm, k, obs_ready, k > lat);
            end
            if (k >= lat) begin
                want = w ? 32'd0 : exp;
                vectors++;
                if (obs_resp_data !== want) begin
                    miscompares++;
                    $display("FAIL %s cyc%0d resp_data got %h want %h", nm, k, obs_resp_data, want);
                end
            end
            if (k == 1) begin
                req_valid = 1'b0;
                if (perturb) begin
                    req_valid = 1'b1; req_wren = 1'b1;
                    req_address = 10'h080; req_write_data = 32'h55555555;
                end
            end
            if (k == lat) req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (obs_ready !== 1'b0) begin miscompares++; $display("FAIL reset req_ready got %b want 0", obs_ready); end
        vectors++; if (obs_resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset resp_valid got %b want 0", obs_resp_valid); end
        vectors++; if (obs_busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", obs_busy); end
        vectors++; if (obs_resp_data !== 32'd0) begin miscompares++; $display("FAIL reset resp_data got %h want 0", obs_resp_data); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL release req_ready got %b want 1", obs_ready); end
    endtask

    task automatic test_store_load();
        sel = 1'b0;
        access(1'b1, 10'h010, 32'hDEADBEEF, 32'd0, 1'b0, "st010");
        access(1'b0, 10'h010, 32'd0, 32'hDEADBEEF, 1'b0, "ld010");
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        access(1'b1, 10'h000, 32'hA5A5A5A5, 32'd0, 1'b0, "l1_st000");
        access(1'b1, 10'h004, 32'h5A5A5A5A, 32'd0, 1'b0, "l1_st004");
        vectors++; if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL b2b c0 req_ready got %b want 1", obs_ready); end
        req_valid = 1'b1; req_wren = 1'b0; req_address = 10'h000;
        @(negedge clk);
        vectors++; if (obs_resp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b c1 resp_valid got %b want 1", obs_resp_valid); end
        vectors++; if (obs_resp_data !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL b2b c1 resp_data got %h want a5a5a5a5", obs_resp_data); end
        vectors++; if (obs_ready !== 1'b0) begin miscompares++; $display("FAIL b2b c1 req_ready got %b want 0", obs_ready); end
        req_address = 10'h004;
        @(negedge clk);
        vectors++; if (obs_resp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b c2 resp_valid got %b want 0", obs_resp_valid); end
        vectors++; if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL b2b c2 req_ready got %b want 1", obs_ready); end
        @(negedge clk);
        vectors++; if (obs_resp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b c3 resp_valid got %b want 1", obs_resp_valid); end
        vectors++; if (obs_resp_data !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL b2b c3 resp_data got %h want 5a5a5a5a", obs_resp_data); end
        req_valid = 1'b0;
        @(negedge clk);
        vectors++; if (obs_resp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b c4 resp_valid got %b want 0", obs_resp_valid); end
        vectors++; if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL b2b c4 req_ready got %b want 1", obs_ready); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        sel = 1'b0;
        access(1'b1, 10'h020, 32'h11111111, 32'd0, 1'b0, "st020_pre");
        req_valid = 1'b1; req_wren = 1'b1; req_address = 10'h020; req_write_data = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++; if (obs_resp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst hold%0d resp_valid got %b want 0", k, obs_resp_valid); end
            vectors++; if (obs_busy !== 1'b0) begin miscompares++; $display("FAIL midrst hold%0d busy got %b want 0", k, obs_busy); end
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++; if (obs_resp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst after%0d resp_valid got %b want 0", k, obs_resp_valid); end
        end
        access(1'b0, 10'h020, 32'd0, 32'h11111111, 1'b0, "ld020_after_rst");
    endtask

    task automatic test_input_change();
        sel = 1'b0;
        access(1'b1, 10'h080, 32'h0BADF00D, 32'd0, 1'b0, "st080");
        access(1'b1, 10'h030, 32'h76543210, 32'd0, 1'b1, "st030_perturb");
        access(1'b0, 10'h030, 32'd0, 32'h76543210, 1'b0, "ld030");
        access(1'b0, 10'h080, 32'd0, 32'h0BADF00D, 1'b0, "ld080_untouched");
    endtask

    task automatic test_wrap();
        sel = 1'b0;
        access(1'b1, 10'h000, 32'h00C0FFEE, 32'd0, 1'b0, "st000");
        access(1'b1, 10'h3FC, 32'hCAFEF00D, 32'd0, 1'b0, "st3fc");
        access(1'b0, 10'h3FC, 32'd0, 32'hCAFEF00D, 1'b0, "ld3fc");
        access(1'b0, 10'h000, 32'd0, 32'h00C0FFEE, 1'b0, "ld000");
        access(1'b0, 10'h3FE, 32'd0, 32'hCAFEF00D, 1'b0, "ld3fe_lowbits");
    endtask

`ifdef DATA_MEMORY_RESPONDER_BYTE_STRB_EN
    task automatic test_byte_strobe();
        sel = 1'b0;
        byte_en = 4'hF;
        access(1'b1, 10'h040, 32'hFFFFFFFF, 32'd0, 1'b0, "st040_full");
        byte_en = 4'b0101;
        access(1'b1, 10'h040, 32'h00000000, 32'd0, 1'b0, "st040_0101");
        byte_en = 4'b0000;
        access(1'b1, 10'h040, 32'h12345678, 32'd0, 1'b0, "st040_none");
        byte_en = 4'hF;
        access(1'b0, 10'h040, 32'd0, 32'hFF00FF00, 1'b0, "ld040_strb");
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_reset_mid_access();
        test_input_change();
        test_wrap();
`ifdef DATA_MEMORY_RESPONDER_BYTE_STRB_EN
        test_byte_strobe();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
